mc_control_alu: RTL and testbench

Multicycle RV32I control and execute block. It combines three parts:
- the main control FSM,
- the ALU-operation decoder,
- the 32-bit integer ALU.

It sits beside the core datapath (PC, register bank, IR, muxes, holding registers). It drives all datapath mux selects and write enables, and computes the ALU result and zero flag each cycle.

---
 rtl/mc_control_alu_pkg.sv | 70 +++++++
 rtl/mc_control_alu_alu.sv | 50 +++++
 rtl/mc_control_alu.sv | 218 +++++++++++++++++++++
 tb/tb_mc_control_alu.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_alu_pkg.sv
// ============================================================================
// mc_control_alu_pkg
// Shared definitions for the multicycle RV32I control/execute block:
//   - RV32I major opcode constants
//   - 4-bit ALU operation codes
//   - aluop class codes (control FSM -> ALU-operation decoder)
//   - datapath mux select encodings for the A and B operand muxes
//   - main control FSM state enumeration
// ============================================================================
package mc_control_alu_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_SGE  = 4'b1010,
        ALU_SGEU = 4'b1011,
        ALU_SEQ  = 4'b1100,
        ALU_SNE  = 4'b1101
    } alu_op_e;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNC   = 2'b10;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_RS1    = 2'd1;
    localparam logic [1:0] SRC_A_PC_OLD = 2'd2;
    localparam logic [1:0] SRC_A_ZERO   = 2'd3;

    localparam logic [1:0] SRC_B_RS2    = 2'd0;
    localparam logic [1:0] SRC_B_FOUR   = 2'd1;
    localparam logic [1:0] SRC_B_IMM    = 2'd2;
    localparam logic [1:0] SRC_B_ZERO   = 2'd3;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMREAD,
        ST_MEMWB,
        ST_MEMWRITE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_LUI,
        ST_ALU_WB,
        ST_BRANCH,
        ST_JALR_CALC,
        ST_JUMP,
        ST_HALT
    } state_e;

endpackage

// File: rtl/mc_control_alu_alu.sv
// ============================================================================
// mc_alu
// Purely combinational XLEN-bit integer ALU.
// Ports:
//   operation  in  4     ALU operation code (alu_op_e); unknown codes give 0
//   x          in  XLEN  operand A
//   y          in  XLEN  operand B (shift amount is y[4:0])
//   result     out XLEN  operation result, wraps modulo 2^XLEN
//   zero       out 1     result == 0
// ============================================================================
module mc_alu
    import mc_control_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      operation,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [4:0] shamt;
    assign shamt = y[4:0];

    // Compare operations produce a single 0/1 in the LSB.
    always_comb begin
        result = '0;
        case (operation)
            ALU_AND:  result = x & y;
            ALU_OR:   result = x | y;
            ALU_ADD:  result = x + y;
            ALU_XOR:  result = x ^ y;
            ALU_SLL:  result = x << shamt;
            ALU_SRL:  result = x >> shamt;
            ALU_SUB:  result = x - y;
            ALU_SRA:  result = $unsigned($signed(x) >>> shamt);
            ALU_SLT:  result[0] = $signed(x) <  $signed(y);
            ALU_SLTU: result[0] = x <  y;
            ALU_SGE:  result[0] = $signed(x) >= $signed(y);
            ALU_SGEU: result[0] = x >= y;
            ALU_SEQ:  result[0] = x == y;
            ALU_SNE:  result[0] = x != y;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mc_control_alu.sv
// ============================================================================
// mc_control_alu
// Multicycle RV32I control and execute block: Moore control FSM, ALU-operation
// decoder and the XLEN-bit ALU (mc_alu).
// Optional feature macro: ILLEGAL_HALT_EN -- when defined, an unknown opcode
// in DECODE parks the FSM in HALT (all outputs 0) until reset; otherwise the
// instruction is treated as a NOP and the FSM returns to FETCH.
// Ports:
//   clk, reset (async, active-low)
//   instruction_opcode/func3/func7   IR fields
//   alu_in_x/alu_in_y                ALU operands from the A/B muxes
//   pc_write, pc_write_cond, pc_load PC update controls
//   lorD, memory_read, memory_write  memory controls
//   memory_to_reg, ir_write, reg_write, pc_source, alu_src_a, alu_src_b
//   is_immediate, aluop, aluop_out   execute-class and decoded ALU op
//   alu_out, zero                    combinational ALU result and zero flag
// ============================================================================
module mc_control_alu
    import mc_control_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [6:0]      instruction_opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] alu_in_x,
    input  logic [XLEN-1:0] alu_in_y,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            pc_load,
    output logic            lorD,
    output logic            memory_read,
    output logic            memory_write,
    output logic            memory_to_reg,
    output logic            ir_write,
    output logic            pc_source,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            reg_write,
    output logic            is_immediate,
    output logic [1:0]      aluop,
    output logic [3:0]      aluop_out,
    output logic [XLEN-1:0] alu_out,
    output logic            zero
);

    state_e state, next_state;

    // Only func7[5] selects SUB/SRA; the remaining bits are don't-care here.
    logic func7_unused;
    assign func7_unused = ^{func7[6], func7[4:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_FETCH;
        else        state <= next_state;
    end

    // Moore decode; everything stays 0 while reset is held low, even though
    // the state register already sits in FETCH.
    always_comb begin
        next_state    = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        lorD          = 1'b0;
        memory_read   = 1'b0;
        memory_write  = 1'b0;
        memory_to_reg = 1'b0;
        ir_write      = 1'b0;
        pc_source     = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        reg_write     = 1'b0;
        is_immediate  = 1'b0;
        aluop         = ALUOP_ADD;
        if (reset) begin
            case (state)
                ST_FETCH: begin
                    memory_read = 1'b1;
                    ir_write    = 1'b1;
                    pc_write    = 1'b1;
                    alu_src_b   = SRC_B_FOUR;
                    next_state  = ST_DECODE;
                end
                ST_DECODE: begin
                    alu_src_a = SRC_A_PC_OLD;
                    alu_src_b = SRC_B_IMM;
                    case (instruction_opcode)
                        OPC_LOAD, OPC_STORE: next_state = ST_MEMADR;
                        OPC_OP:     next_state = ST_EXEC_R;
                        OPC_OPIMM:  next_state = ST_EXEC_I;
                        OPC_BRANCH: next_state = ST_BRANCH;
                        OPC_JAL:    next_state = ST_JUMP;
                        OPC_JALR:   next_state = ST_JALR_CALC;
                        OPC_LUI:    next_state = ST_LUI;
                        OPC_AUIPC:  next_state = ST_ALU_WB;
`ifdef ILLEGAL_HALT_EN
                        default:    next_state = ST_HALT;
`else
                        default:    next_state = ST_FETCH;
`endif
                    endcase
                end
                ST_MEMADR: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_IMM;
                    next_state = (instruction_opcode == OPC_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
                end
                ST_MEMREAD: begin
                    memory_read = 1'b1;
                    lorD        = 1'b1;
                    next_state  = ST_MEMWB;
                end
                ST_MEMWB: begin
                    reg_write     = 1'b1;
                    memory_to_reg = 1'b1;
                    next_state    = ST_FETCH;
                end
                ST_MEMWRITE: begin
                    memory_write = 1'b1;
                    lorD         = 1'b1;
                    next_state   = ST_FETCH;
                end
                ST_EXEC_R: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_RS2;
                    aluop      = ALUOP_FUNC;
                    next_state = ST_ALU_WB;
                end
                ST_EXEC_I: begin
                    alu_src_a    = SRC_A_RS1;
                    alu_src_b    = SRC_B_IMM;
                    aluop        = ALUOP_FUNC;
                    is_immediate = 1'b1;
                    next_state   = ST_ALU_WB;
                end
                ST_LUI: begin
                    alu_src_a  = SRC_A_ZERO;
                    alu_src_b  = SRC_B_IMM;
                    next_state = ST_ALU_WB;
                end
                ST_ALU_WB: begin
                    reg_write  = 1'b1;
                    next_state = ST_FETCH;
                end
                ST_BRANCH: begin
                    alu_src_a     = SRC_A_RS1;
                    alu_src_b     = SRC_B_RS2;
                    aluop         = ALUOP_BRANCH;
                    pc_source     = 1'b1;
                    // func3 010/011 are not branches: never taken.
                    pc_write_cond = (func3 != 3'b010) && (func3 != 3'b011);
                    next_state    = ST_FETCH;
                end
                ST_JALR_CALC: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_IMM;
                    next_state = ST_JUMP;
                end
                ST_JUMP: begin
                    // Target comes from ALUOut; PC (already +4) passes the ALU
                    // with +0 so ALUOut captures the link address.
                    alu_src_a  = SRC_A_PC;
                    alu_src_b  = SRC_B_ZERO;
                    pc_write   = 1'b1;
                    pc_source  = 1'b1;
                    next_state = ST_ALU_WB;
                end
                ST_HALT:  next_state = ST_HALT;
                default:  next_state = ST_FETCH;
            endcase
        end
    end

    // ALU-operation decoder. For branches the op is chosen so that a zero
    // result means "branch taken".
    always_comb begin
        aluop_out = ALU_ADD;
        case (aluop)
            ALUOP_FUNC: begin
                case (func3)
                    3'b000:  aluop_out = (func7[5] && !is_immediate) ? ALU_SUB : ALU_ADD;
                    3'b001:  aluop_out = ALU_SLL;
                    3'b010:  aluop_out = ALU_SLT;
                    3'b011:  aluop_out = ALU_SLTU;
                    3'b100:  aluop_out = ALU_XOR;
                    3'b101:  aluop_out = func7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  aluop_out = ALU_OR;
                    default: aluop_out = ALU_AND;
                endcase
            end
            ALUOP_BRANCH: begin
                case (func3)
                    3'b000:  aluop_out = ALU_SUB;
                    3'b001:  aluop_out = ALU_SEQ;
                    3'b100:  aluop_out = ALU_SGE;
                    3'b101:  aluop_out = ALU_SLT;
                    3'b110:  aluop_out = ALU_SGEU;
                    3'b111:  aluop_out = ALU_SLTU;
                    default: aluop_out = ALU_ADD;
                endcase
            end
            default: aluop_out = ALU_ADD;
        endcase
    end

    mc_alu #(.XLEN(XLEN)) u_alu (
        .operation (aluop_out),
        .x         (alu_in_x),
        .y         (alu_in_y),
        .result    (alu_out),
        .zero      (zero)
    );

    assign pc_load = pc_write | (pc_write_cond & zero);

endmodule

// File: tb/tb_mc_control_alu.sv
// ============================================================================
// tb_mc_control_alu
// Scoreboard bench for mc_control_alu: stimulus walks instructions through the
// FSM and queues the hand-computed expectations for each cycle; a monitor on
// the falling edge pops and compares everything queued for that cycle.
// ============================================================================
module tb_mc_control_alu;

    localparam int XLEN = 32;

    localparam int F_CTRL  = 0;
    localparam int F_ALUOP = 1;
    localparam int F_RES   = 2;
    localparam int F_ZERO  = 3;
    localparam int F_LOAD  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [6:0]      instruction_opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] alu_in_x, alu_in_y;
    logic            pc_write, pc_write_cond, pc_load, lorD, memory_read, memory_write;
    logic            memory_to_reg, ir_write, pc_source, reg_write, is_immediate, zero;
    logic [1:0]      alu_src_a, alu_src_b, aluop;
    logic [3:0]      aluop_out;
    logic [XLEN-1:0] alu_out;

    mc_control_alu #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .instruction_opcode(instruction_opcode), .func3(func3), .func7(func7),
        .alu_in_x(alu_in_x), .alu_in_y(alu_in_y),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_load(pc_load),
        .lorD(lorD), .memory_read(memory_read), .memory_write(memory_write),
        .memory_to_reg(memory_to_reg), .ir_write(ir_write), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
        .is_immediate(is_immediate), .aluop(aluop), .aluop_out(aluop_out),
        .alu_out(alu_out), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          field;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   testsRun = 0;
    int   testsFailed = 0;

    always @(posedge clk) cyc++;

    // Packed control word: pw,pwc,lorD,mr,mw,m2r,irw,psrc,srcA,srcB,rw,imm,aluop
    function automatic logic [15:0] cw(input bit pw, pwc, ld, mr, mw, m2r, irw, ps,
                                       input bit [1:0] sa, sb, input bit rw, imm,
                                       input bit [1:0] op);
        return {pw, pwc, ld, mr, mw, m2r, irw, ps, sa, sb, rw, imm, op};
    endfunction

    // Monitor: compare everything expected for the current cycle.
    always @(negedge clk) begin
        logic [31:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            case (e.field)
                F_CTRL:  act = {16'b0, pc_write, pc_write_cond, lorD, memory_read, memory_write,
                                memory_to_reg, ir_write, pc_source, alu_src_a, alu_src_b,
                                reg_write, is_immediate, aluop};
                F_ALUOP: act = {28'b0, aluop_out};
                F_RES:   act = alu_out;
                F_ZERO:  act = {31'b0, zero};
                default: act = {31'b0, pc_load};
            endcase
            testsRun++;
            if (e.cyc != cyc || act !== e.exp) begin
                testsFailed++;
                $display("[TB] FAIL %s (cycle %0d/%0d): got %h, expected %h",
                         e.name, cyc, e.cyc, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int field, input logic [31:0] exp);
        q.push_back('{cyc, field, exp, name});
    endtask

    task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] x, input logic [31:0] y);
        instruction_opcode = opc;
        func3 = f3;
        func7 = f7;
        alu_in_x = x;
        alu_in_y = y;
    endtask

    task automatic expFetch(input string n);
        checkOutput({n, " FETCH"}, F_CTRL, {16'b0, cw(1,0,0,1,0,0,1,0, 2'd0,2'd1, 0,0,2'd0)});
    endtask
    task automatic expDecode(input string n);
        checkOutput({n, " DECODE"}, F_CTRL, {16'b0, cw(0,0,0,0,0,0,0,0, 2'd2,2'd2, 0,0,2'd0)});
    endtask
    task automatic expAluWb(input string n);
        checkOutput({n, " ALU_WB"}, F_CTRL, {16'b0, cw(0,0,0,0,0,0,0,0, 2'd0,2'd0, 1,0,2'd0)});
    endtask

    // R-type or I-type ALU instruction, starting and ending in FETCH.
    task automatic runExec(input string n, input bit isImm, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] x, input logic [31:0] y,
                           input logic [3:0] expOp, input logic [31:0] expRes);
        applyStimulus(isImm ? 7'b0010011 : 7'b0110011, f3, f7, x, y);
        expFetch(n); tick();
        expDecode(n); tick();
        if (isImm)
            checkOutput({n, " EXEC_I"}, F_CTRL, {16'b0, cw(0,0,0,0,0,0,0,0, 2'd1,2'd2, 0,1,2'd2)});
        else
            checkOutput({n, " EXEC_R"}, F_CTRL, {16'b0, cw(0,0,0,0,0,0,0,0, 2'd1,2'd0, 0,0,2'd2)});
        checkOutput({n, " aluop_out"}, F_ALUOP, {28'b0, expOp});
        checkOutput({n, " alu_out"}, F_RES, expRes);
        checkOutput({n, " zero"}, F_ZERO, {31'b0, expRes == 32'h0});
        tick();
        expAluWb(n); tick();
    endtask

    task automatic runBranch(input string n, input logic [2:0] f3, input logic [31:0] x,
                             input logic [31:0] y, input logic [3:0] expOp,
                             input logic [31:0] expRes, input bit expLoad);
        bit pwc;
        pwc = (f3 != 3'b010) && (f3 != 3'b011);
        applyStimulus(7'b1100011, f3, 7'b0, x, y);
        expFetch(n); tick();
        expDecode(n); tick();
        checkOutput({n, " BRANCH"}, F_CTRL, {16'b0, cw(0,pwc,0,0,0,0,0,1, 2'd1,2'd0, 0,0,2'd1)});
        checkOutput({n, " aluop_out"}, F_ALUOP, {28'b0, expOp});
        checkOutput({n, " alu_out"}, F_RES, expRes);
        checkOutput({n, " pc_load"}, F_LOAD, {31'b0, expLoad});
        tick();
    endtask

    task automatic runMem(input string n, input bit isLoad);
        applyStimulus(isLoad ? 7'b0000011 : 7'b0100011, 3'b010, 7'b0, 32'h100, 32'h8);
        expFetch(n); tick();
        expDecode(n); tick();
        checkOutput({n, " MEMADR"}, F_CTRL, {16'b0, cw(0,0,0,0,0,0,0,0, 2'd1,2'd2, 0,0,2'd0)});
        checkOutput({n, " addr"}, F_RES, 32'h108);
        tick();
        if (isLoad) begin
            checkOutput({n, " MEMREAD"}, F_CTRL, {16'b0, cw(0,0,1,1,0,0,0,0, 2'd0,2'd0, 0,0,2'd0)});
            tick();
            checkOutput({n, " MEMWB"}, F_CTRL, {16'b0, cw(0,0,0,0,0,1,0,0, 2'd0,2'd0, 1,0,2'd0)});
        end else begin
            checkOutput({n, " MEMWRITE"}, F_CTRL, {16'b0, cw(0,0,1,0,1,0,0,0, 2'd0,2'd0, 0,0,2'd0)});
        end
        tick();
    endtask

    task automatic runJump(input string n, input bit isJalr);
        applyStimulus(isJalr ? 7'b1100111 : 7'b1101111, 3'b000, 7'b0, 32'h40, 32'h0);
        expFetch(n); tick();
        expDecode(n); tick();
        if (isJalr) begin
            checkOutput({n, " JALR_CALC"}, F_CTRL, {16'b0, cw(0,0,0,0,0,0,0,0, 2'd1,2'd2, 0,0,2'd0)});
            tick();
        end
        checkOutput({n, " JUMP"}, F_CTRL, {16'b0, cw(1,0,0,0,0,0,0,1, 2'd0,2'd3, 0,0,2'd0)});
        checkOutput({n, " pc_load"}, F_LOAD, 32'h1);
        checkOutput({n, " link"}, F_RES, 32'h40);
        tick();
        expAluWb(n); tick();
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(7'b0110011, 3'b000, 7'b0, 32'd3, 32'd4);
        tick(); tick();
        checkOutput("reset ctrl", F_CTRL, 32'h0);
        checkOutput("reset alu_out", F_RES, 32'd7);
        tick();
        reset = 1'b1;

        // Abort an R-type in EXEC_R with reset, then restart from FETCH.
        applyStimulus(7'b0110011, 3'b000, 7'b0100000, 32'd5, 32'd7);
        expFetch("abort"); tick();
        expDecode("abort"); tick();
        checkOutput("abort EXEC_R", F_CTRL, {16'b0, cw(0,0,0,0,0,0,0,0, 2'd1,2'd0, 0,0,2'd2)});
        @(negedge clk); #1;
        reset = 1'b0;
        tick();
        checkOutput("abort held ctrl", F_CTRL, 32'h0);
        tick();
        reset = 1'b1;

        runExec("SUB",   0, 3'b000, 7'b0100000, 32'd5,        32'd7,        4'b0110, 32'hFFFFFFFE);
        runExec("ADDwr", 0, 3'b000, 7'b0000000, 32'hFFFFFFFF, 32'd1,        4'b0010, 32'h0);
        runExec("SLT",   0, 3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1,        4'b1000, 32'd1);
        runExec("SLTU",  0, 3'b011, 7'b0000000, 32'hFFFFFFFF, 32'd1,        4'b1001, 32'd0);
        runExec("SLL",   0, 3'b001, 7'b0000000, 32'd1,        32'h3F,       4'b0100, 32'h80000000);
        runExec("SRL",   0, 3'b101, 7'b0000000, 32'h80000000, 32'd31,       4'b0101, 32'd1);
        runExec("XOR",   0, 3'b100, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0011, 32'h0FF00FF0);
        runExec("OR",    0, 3'b110, 7'b0000000, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'b0001, 32'hFFFFFFFF);
        runExec("AND",   0, 3'b111, 7'b0000000, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'b0000, 32'h0);
        runExec("ADDI",  1, 3'b000, 7'b0100000, 32'd5,        32'd7,        4'b0010, 32'd12);
        runExec("SRAI",  1, 3'b101, 7'b0100000, 32'h80000000, 32'd4,        4'b0111, 32'hF8000000);

        runBranch("BEQ",  3'b000, 32'd9,        32'd9,        4'b0110, 32'd0, 1'b1);
        runBranch("BNE",  3'b001, 32'd9,        32'd9,        4'b1100, 32'd1, 1'b0);
        runBranch("BLT",  3'b100, 32'd3,        32'd2,        4'b1010, 32'd1, 1'b0);
        runBranch("BGE",  3'b101, 32'hFFFFFFFF, 32'd1,        4'b1000, 32'd1, 1'b0);
        runBranch("BLTU", 3'b110, 32'd1,        32'hFFFFFFFF, 4'b1011, 32'd0, 1'b1);
        runBranch("BGEU", 3'b111, 32'd5,        32'd5,        4'b1001, 32'd0, 1'b1);
        runBranch("B010", 3'b010, 32'd0,        32'd0,        4'b0010, 32'd0, 1'b0);

        runMem("LW", 1'b1);
        runMem("SW", 1'b0);
        runJump("JAL", 1'b0);
        runJump("JALR", 1'b1);

        applyStimulus(7'b0110111, 3'b000, 7'b0, 32'h0, 32'h12345000);
        expFetch("LUI"); tick();
        expDecode("LUI"); tick();
        checkOutput("LUI state", F_CTRL, {16'b0, cw(0,0,0,0,0,0,0,0, 2'd3,2'd2, 0,0,2'd0)});
        checkOutput("LUI alu_out", F_RES, 32'h12345000);
        tick();
        expAluWb("LUI"); tick();

        applyStimulus(7'b0010111, 3'b000, 7'b0, 32'h0, 32'h0);
        expFetch("AUIPC"); tick();
        expDecode("AUIPC"); tick();
        expAluWb("AUIPC"); tick();

        applyStimulus(7'b1111111, 3'b000, 7'b0, 32'h0, 32'h0);
        expFetch("ILL"); tick();
        expDecode("ILL"); tick();
`ifdef ILLEGAL_HALT_EN
        checkOutput("ILL HALT", F_CTRL, 32'h0); tick();
        checkOutput("ILL HALT stays", F_CTRL, 32'h0); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
`endif
        expFetch("after ILL"); tick();
        expDecode("after ILL"); tick();

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", q.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
